// File: rtl/pipe_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package pipe_fetch_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pipe_fetch_hold_buf.sv
// Holding buffer for the instruction in flight when a stall begins.
// The memory only presents its data for one cycle, so the word and its
// address are captured here and replayed until the stall releases.
module fetch_hold_buf
    import pipe_fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cap_en_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] resp_pc_i,
    output logic [31:0] hold_inst_o,
    output logic [31:0] hold_pc_o
);

    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;

    // Load a new word only on the capture cycle; otherwise keep it.
    always_comb begin
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        if (cap_en_i) begin
            hold_inst_d = rdata_i;
            hold_pc_d   = resp_pc_i;
        end
    end

    // Buffer registers with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= 32'h0;
        end else begin
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
        end
    end

    assign hold_inst_o = hold_inst_q;
    assign hold_pc_o   = hold_pc_q;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction-fetch stage: owns the PC, drives a synchronous-read
// instruction memory and presents pc4/inst to the IF/ID register.
// stall outranks branch, exactly as in the IF/ID register, so a word is
// never lost or duplicated. A redirect issues the target in the same
// cycle, so the target word appears on inst in the very next cycle.
module pipe_fetch
    import pipe_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc4,
    output logic [31:0] inst
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic         capture;
    logic [31:0]  hold_inst, hold_pc;
    logic [31:0]  target;
    logic         redirect;

    assign target = align_pc(branch_target);

    // A redirect is taken only once the stage is running and not stalled.
    assign redirect = !rst && (state_q != BOOT) && branch && !stall;

    // Issue address: the branch target bypasses fetch_pc so no bubble is added.
    assign imem_addr = redirect ? target : fetch_pc_q;

    fetch_hold_buf u_hold (
        .clk_i       (clk),
        .rst_i       (rst),
        .cap_en_i    (capture),
        .rdata_i     (imem_rdata),
        .resp_pc_i   (resp_pc_q),
        .hold_inst_o (hold_inst),
        .hold_pc_o   (hold_pc)
    );

    // Per-state outputs and next-state selection.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        imem_en    = 1'b0;
        inst       = NOP_INST;
        pc4        = 32'h0;
        capture    = 1'b0;
        if (!rst) begin
            case (state_q)
                BOOT: begin
                    imem_en    = 1'b1;
                    resp_pc_d  = RESET_PC;
                    fetch_pc_d = RESET_PC + PC_STEP;
                    state_d    = RUN;
                end
                RUN: begin
                    if (stall) begin
                        inst    = imem_rdata;
                        pc4     = resp_pc_q + PC_STEP;
                        capture = 1'b1;
                        state_d = HOLD;
                    end else if (branch) begin
                        imem_en    = 1'b1;
                        resp_pc_d  = target;
                        fetch_pc_d = target + PC_STEP;
                    end else begin
                        inst       = imem_rdata;
                        pc4        = resp_pc_q + PC_STEP;
                        imem_en    = 1'b1;
                        resp_pc_d  = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        inst = hold_inst;
                        pc4  = hold_pc + PC_STEP;
                    end else if (branch) begin
                        imem_en    = 1'b1;
                        resp_pc_d  = target;
                        fetch_pc_d = target + PC_STEP;
                        state_d    = RUN;
                    end else begin
                        inst       = hold_inst;
                        pc4        = hold_pc + PC_STEP;
                        imem_en    = 1'b1;
                        resp_pc_d  = fetch_pc_q;
                        fetch_pc_d = fetch_pc_q + PC_STEP;
                        state_d    = RUN;
                    end
                end
                default: begin
                    state_d = BOOT;
                end
            endcase
        end
    end

    // FSM and PC registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
        end
    end

endmodule
